v60_prefetch_queue: RTL and testbench

//  Instruction prefetch queue directly upstream of v60_decoder. Fetches aligned 32-bit words from
//  the instruction bus and buffers them as a byte FIFO. Presents the 6 oldest bytes as the 48-bit

---
 rtl/v60_prefetch_queue_if.sv | 10 +
 rtl/v60_prefetch_queue.sv | 152 +++++++++++++++
 tb/tb_v60_prefetch_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/v60_prefetch_queue_if.sv
// Instruction-bus fetch channel between the prefetch queue (master) and memory (slave).
interface v60_prefetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/v60_prefetch_queue.sv
// Instruction prefetch queue feeding v60_decoder: aligned word fetches in, byte FIFO out,
// with the six oldest bytes presented as the decode window.
module v60_prefetch_queue #(
  parameter int unsigned QUEUE_BYTES = 16,
  parameter logic [31:0] RESET_PC    = 32'hFFFF_FFF0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [31:0]                 flush_pc,
  v60_prefetch_queue_if.master        mem,
  output logic [47:0]                 inst,
  output logic                        inst_valid,
  output logic [4:0]                  avail_bytes,
  output logic [31:0]                 inst_pc,
  input  logic                        consume,
  input  logic [2:0]                  consume_len
);
  localparam int unsigned AW = $clog2(QUEUE_BYTES);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]      state, state_nxt;
  logic            req_q, req_nxt;
  logic [31:0]     addr_q, addr_nxt;
  logic [31:0]     fetch_q, fetch_nxt;
  logic [31:0]     pc_q, pc_nxt;
  logic [1:0]      skip_q, skip_nxt;
  logic [CW-1:0]   count_q, count_nxt;
  logic [7:0]      q     [QUEUE_BYTES];
  logic [7:0]      q_nxt [QUEUE_BYTES];

  logic [CW-1:0]   pop_n;
  logic [CW-1:0]   base;
  logic [CW-1:0]   src;
  logic [CW-1:0]   dst;
  logic            push_en;
  logic [2:0]      push_cnt;
  logic [3:0][7:0] wbytes;
  logic [5:0][7:0] win;

  // Fetch FSM: one request in flight; a flush during a request turns it into a drop.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    fetch_nxt = fetch_q;
    skip_nxt  = skip_q;
    case (state)
      IDLE: begin
        if (!flush && (count_q <= CW'(QUEUE_BYTES - 4))) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_q;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (!flush) begin
            fetch_nxt = fetch_q + 32'd4;
            skip_nxt  = 2'd0;
          end
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (mem.mem_ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
    if (flush) begin
      fetch_nxt = {flush_pc[31:2], 2'b00};
      skip_nxt  = flush_pc[1:0];
    end
  end

  // Byte FIFO kept head-aligned: pop shifts toward entry 0, push lands after the survivors.
  always_comb begin
    pop_n = '0;
    if (consume && !flush)
      pop_n = (CW'(consume_len) > count_q) ? count_q : CW'(consume_len);
    push_en  = (state == REQ) && mem.mem_ack && !flush;
    push_cnt = 3'd4 - {1'b0, skip_q};
    wbytes   = mem.mem_rdata >> {skip_q, 3'b000};
    base     = count_q - pop_n;
    src      = '0;
    dst      = '0;
    for (int unsigned i = 0; i < QUEUE_BYTES; i++) begin
      src = CW'(i) + pop_n;
      q_nxt[AW'(i)] = (src < CW'(QUEUE_BYTES)) ? q[AW'(src)] : 8'h00;
    end
    if (push_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (3'(k) < push_cnt) begin
          dst = base + CW'(k);
          q_nxt[AW'(dst)] = wbytes[2'(k)];
        end
      end
    end
    count_nxt = flush ? '0 : (base + (push_en ? CW'(push_cnt) : CW'(0)));
    pc_nxt    = flush ? flush_pc : (pc_q + 32'(pop_n));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= {RESET_PC[31:2], 2'b00};
      fetch_q <= {RESET_PC[31:2], 2'b00};
      pc_q    <= RESET_PC;
      skip_q  <= RESET_PC[1:0];
      count_q <= '0;
      for (int unsigned i = 0; i < QUEUE_BYTES; i++) q[AW'(i)] <= 8'h00;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      fetch_q <= fetch_nxt;
      pc_q    <= pc_nxt;
      skip_q  <= skip_nxt;
      count_q <= count_nxt;
      q       <= q_nxt;
    end
  end

  // Decode window: oldest byte in the top lane, lanes past the byte count read zero.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 6; i++)
      win[3'(5 - i)] = (CW'(i) < count_q) ? q[AW'(i)] : 8'h00;
  end

  assign inst         = win;
  assign inst_valid   = (count_q >= CW'(6));
  assign avail_bytes  = 5'(count_q);
  assign inst_pc      = pc_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Directed bench for v60_prefetch_queue: a vector table of consume/flush steps from a
// settled queue, plus hand sequences for delayed acks, push+pop overlap and reset.
module tb_v60_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        consume;
  logic [2:0]  consume_len;
  logic [47:0] inst;
  logic        inst_valid;
  logic [4:0]  avail_bytes;
  logic [31:0] inst_pc;

  v60_prefetch_queue_if mem();

  v60_prefetch_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .mem        (mem),
    .inst       (inst),
    .inst_valid (inst_valid),
    .avail_bytes(avail_bytes),
    .inst_pc    (inst_pc),
    .consume    (consume),
    .consume_len(consume_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        cons;
    logic [2:0]  clen;
    logic [4:0]  now_av;
    logic [31:0] now_pc;
    logic [4:0]  set_av;
    logic [47:0] set_inst;
    int          nreq;
  } vec_t;

  vec_t        vt [8];
  int          total = 0;
  int          bad = 0;
  int          nreq = 0;
  int          wcnt = 0;
  int          lat = 1;
  bit          auto_ack = 1'b0;
  logic [31:0] addr_log [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic ack_word();
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = word_at(mem.mem_addr);
    nreq++;
    addr_log.push_back(mem.mem_addr);
  endtask

  // One cycle: advance to the next falling edge, then play memory if auto-ack is on.
  task automatic tick();
    @(negedge clk);
    mem.mem_ack = 1'b0;
    if (auto_ack && rst_n && mem.mem_req) begin
      wcnt++;
      if (wcnt >= lat) begin
        ack_word();
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 40 && !mem.mem_req; i++) tick();
    chk(nm, 64'(mem.mem_req), 64'(1'b1));
  endtask

  function automatic logic [31:0] log_at(input int idx);
    return (idx < addr_log.size()) ? addr_log[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n0;
    int logn;
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; consume = 1'b0; consume_len = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;

    vt[0] = '{1'b0, 32'h0,         1'b1, 3'd3, 5'd13, 32'hFFFF_FFF3, 5'd13, 48'hF3F4F5F6F7F8, 0};
    vt[1] = '{1'b0, 32'h0,         1'b1, 3'd1, 5'd12, 32'hFFFF_FFF4, 5'd16, 48'hF4F5F6F7F8F9, 1};
    vt[2] = '{1'b0, 32'h0,         1'b1, 3'd0, 5'd16, 32'hFFFF_FFF4, 5'd16, 48'hF4F5F6F7F8F9, 0};
    vt[3] = '{1'b0, 32'h0,         1'b1, 3'd7, 5'd9,  32'hFFFF_FFFB, 5'd13, 48'hFBFCFDFEFF00, 1};
    vt[4] = '{1'b1, 32'h0000_1006, 1'b1, 3'd5, 5'd0,  32'h0000_1006, 5'd14, 48'h060708090A0B, 4};
    vt[5] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 3'd0, 5'd0,  32'hFFFF_FFFE, 5'd14, 48'hFEFF00010203, 4};
    vt[6] = '{1'b0, 32'h0,         1'b1, 3'd6, 5'd8,  32'h0000_0004, 5'd16, 48'h040506070809, 2};
    vt[7] = '{1'b1, 32'h0000_0003, 1'b0, 3'd0, 5'd0,  32'h0000_0003, 5'd13, 48'h030405060708, 4};

    // reset state
    settle(3);
    chk("rst_req",   64'(mem.mem_req),  64'(1'b0));
    chk("rst_addr",  64'(mem.mem_addr), 64'(32'hFFFF_FFF0));
    chk("rst_inst",  64'(inst),         64'(48'h0));
    chk("rst_valid", 64'(inst_valid),   64'(1'b0));
    chk("rst_avail", 64'(avail_bytes),  64'(5'd0));
    chk("rst_pc",    64'(inst_pc),      64'(32'hFFFF_FFF0));

    // first fill with single-cycle acks
    rst_n = 1'b1; auto_ack = 1'b1; lat = 1;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    chk("fill_valid", 64'(inst_valid), 64'(1'b1));
    chk("fill_addr0", 64'(log_at(0)),  64'(32'hFFFF_FFF0));
    chk("fill_inst",  64'(inst),       64'(48'hF0F1F2F3F4F5));
    chk("fill_pc",    64'(inst_pc),    64'(32'hFFFF_FFF0));
    settle(30);
    chk("fill_full",  64'(avail_bytes), 64'(5'd16));
    chk("fill_noreq", 64'(mem.mem_req), 64'(1'b0));

    // table: one consume/flush step from a settled queue, then let it refill
    for (int i = 0; i < 8; i++) begin
      n0 = nreq;
      flush = vt[i].fl; flush_pc = vt[i].fpc; consume = vt[i].cons; consume_len = vt[i].clen;
      tick();
      flush = 1'b0; consume = 1'b0; consume_len = '0;
      chk($sformatf("v%0d_now_avail", i), 64'(avail_bytes), 64'(vt[i].now_av));
      chk($sformatf("v%0d_now_pc", i),    64'(inst_pc),     64'(vt[i].now_pc));
      settle(30);
      chk($sformatf("v%0d_avail", i), 64'(avail_bytes), 64'(vt[i].set_av));
      chk($sformatf("v%0d_pc", i),    64'(inst_pc),     64'(vt[i].now_pc));
      chk($sformatf("v%0d_inst", i),  64'(inst),        64'(vt[i].set_inst));
      chk($sformatf("v%0d_valid", i), 64'(inst_valid),  64'(vt[i].set_av >= 5'd6));
      chk($sformatf("v%0d_nreq", i),  64'(nreq - n0),   64'(vt[i].nreq));
      chk($sformatf("v%0d_idle", i),  64'(mem.mem_req), 64'(1'b0));
    end

    // flush while a request is outstanding, ack after three cycles
    lat = 3;
    consume = 1'b1; consume_len = 3'd1;
    tick();
    consume = 1'b0; consume_len = '0;
    chk("t4_pre_avail", 64'(avail_bytes), 64'(5'd12));
    wait_req("t4_req");
    chk("t4_addr", 64'(mem.mem_addr), 64'(32'h0000_0010));
    logn = addr_log.size();
    flush = 1'b1; flush_pc = 32'h0000_2000;
    tick();
    flush = 1'b0;
    chk("t4_hold1_req",  64'(mem.mem_req),  64'(1'b1));
    chk("t4_hold1_addr", 64'(mem.mem_addr), 64'(32'h0000_0010));
    tick();
    chk("t4_hold2_req",  64'(mem.mem_req),  64'(1'b1));
    chk("t4_hold2_addr", 64'(mem.mem_addr), 64'(32'h0000_0010));
    tick();
    chk("t4_drop_req",   64'(mem.mem_req),  64'(1'b0));
    chk("t4_drop_avail", 64'(avail_bytes),  64'(5'd0));
    chk("t4_drop_pc",    64'(inst_pc),      64'(32'h0000_2000));
    settle(40);
    chk("t4_next_addr", 64'(log_at(logn + 1)), 64'(32'h0000_2000));
    chk("t4_avail",     64'(avail_bytes),      64'(5'd16));
    chk("t4_inst",      64'(inst),             64'(48'h000102030405));

    // push and pop in the same cycle, acks driven by hand
    auto_ack = 1'b0;
    flush = 1'b1; flush_pc = 32'h0000_3002;
    tick();
    flush = 1'b0;
    wait_req("t5_req0");
    chk("t5_addr0", 64'(mem.mem_addr), 64'(32'h0000_3000));
    ack_word();
    tick();
    wait_req("t5_req1");
    chk("t5_addr1", 64'(mem.mem_addr), 64'(32'h0000_3004));
    ack_word();
    tick();
    chk("t5_avail6", 64'(avail_bytes), 64'(5'd6));
    chk("t5_inst6",  64'(inst),        64'(48'h020304050607));
    wait_req("t5_req2");
    chk("t5_addr2", 64'(mem.mem_addr), 64'(32'h0000_3008));
    ack_word();
    consume = 1'b1; consume_len = 3'd5;
    tick();
    consume = 1'b0; consume_len = '0;
    chk("t5_avail", 64'(avail_bytes), 64'(5'd5));
    chk("t5_pc",    64'(inst_pc),     64'(32'h0000_3007));
    chk("t5_inst",  64'(inst),        64'(48'h0708090A0B00));
    chk("t5_valid", 64'(inst_valid),  64'(1'b0));

    // reset mid-request, then a stray ack and a consume on the empty queue
    wait_req("t7_req");
    rst_n = 1'b0;
    #1;
    chk("t7_rst_req",   64'(mem.mem_req),  64'(1'b0));
    chk("t7_rst_avail", 64'(avail_bytes),  64'(5'd0));
    chk("t7_rst_addr",  64'(mem.mem_addr), 64'(32'hFFFF_FFF0));
    chk("t7_rst_inst",  64'(inst),         64'(48'h0));
    tick();
    rst_n = 1'b1;
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h1234_5678;
    consume = 1'b1; consume_len = 3'd3;
    tick();
    consume = 1'b0; consume_len = '0;
    chk("t7_avail", 64'(avail_bytes),  64'(5'd0));
    chk("t7_pc",    64'(inst_pc),      64'(32'hFFFF_FFF0));
    chk("t7_req",   64'(mem.mem_req),  64'(1'b1));
    chk("t7_addr",  64'(mem.mem_addr), 64'(32'hFFFF_FFF0));
    chk("t7_valid", 64'(inst_valid),   64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
